// File: rtl/icache_nway_pkg.sv
// Shared types, address-split helpers and FSM encoding for the set-associative instruction cache.
package icache_nway_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned DEF_WAYS       = 2;
    localparam int unsigned DEF_SETS       = 64;
    localparam int unsigned DEF_LINE_WORDS = 8;
    localparam int unsigned DEF_FETCH      = 4;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned line_words, input int unsigned sets);
        return 32 - off_w(line_words) - idx_w(sets);
    endfunction

    localparam int unsigned DEF_TAG_W = tag_w(DEF_LINE_WORDS, DEF_SETS);

    typedef logic [DEF_TAG_W-1:0]        tag_t;
    typedef word_t [DEF_LINE_WORDS-1:0]  line_t;

    localparam logic [2:0] ST_INVAL    = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_LOOKUP   = 3'd2;
    localparam logic [2:0] ST_MISS_REQ = 3'd3;
    localparam logic [2:0] ST_REFILL   = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    typedef enum logic [2:0] {
        INVAL    = ST_INVAL,
        IDLE     = ST_IDLE,
        LOOKUP   = ST_LOOKUP,
        MISS_REQ = ST_MISS_REQ,
        REFILL   = ST_REFILL,
        RESP     = ST_RESP
    } state_e;

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side request/response and memory AR/R refill signals of the cache.
interface icache_nway_if #(
    parameter int unsigned FETCH = 4
);
    import icache_nway_pkg::*;

    logic [31:0]         addr;
    logic                addr_valid;
    logic                addr_ready;
    logic                flush;
    logic [32*FETCH-1:0] result;
    logic                result_valid;
    word_t               mem_araddr;
    logic                mem_arvalid;
    logic                mem_arready;
    word_t               mem_rdata;
    logic                mem_rvalid;
    logic                mem_rlast;
    logic                mem_rready;

    modport slave (
        input  addr, addr_valid, flush, mem_arready, mem_rdata, mem_rvalid, mem_rlast,
        output addr_ready, result, result_valid, mem_araddr, mem_arvalid, mem_rready
    );

    modport master (
        output addr, addr_valid, flush, mem_arready, mem_rdata, mem_rvalid, mem_rlast,
        input  addr_ready, result, result_valid, mem_araddr, mem_arvalid, mem_rready
    );

endinterface

// File: rtl/icache_nway_way.sv
// One cache way: tag RAM, valid bits and per-word data RAMs with a registered read port.
module icache_nway_way
    import icache_nway_pkg::*;
#(
    parameter  int unsigned SETS       = 64,
    parameter  int unsigned LINE_WORDS = 8,
    parameter  int unsigned TAG_W      = 21,
    localparam int unsigned IW         = idx_w(SETS),
    localparam int unsigned WW         = clog2_min1(LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_en_i,
    input  logic [IW-1:0]              rd_index_i,
    output logic [TAG_W-1:0]           rd_tag_o,
    output logic                       rd_valid_o,
    output logic [LINE_WORDS-1:0][31:0] rd_line_o,
    input  logic [IW-1:0]              wr_index_i,
    input  logic [WW-1:0]              wr_word_i,
    input  word_t                      wr_data_i,
    input  logic                       wr_data_en_i,
    input  logic                       wr_tag_en_i,
    input  logic [TAG_W-1:0]           wr_tag_i,
    input  logic                       inv_en_i
);

    logic [TAG_W-1:0] tag_mem [SETS];
    logic [SETS-1:0]  valid_q;

    always_ff @(posedge clk) begin
        if (wr_tag_en_i) tag_mem[wr_index_i] <= wr_tag_i;
        if (rd_en_i)     rd_tag_o <= tag_mem[rd_index_i];
    end

    // Invalidate wins over a tag write; the FSM never asks for both at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            if (inv_en_i)         valid_q[wr_index_i] <= 1'b0;
            else if (wr_tag_en_i) valid_q[wr_index_i] <= 1'b1;
            if (rd_en_i)          rd_valid_o <= valid_q[rd_index_i];
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
        word_t data_mem [SETS];
        word_t rd_q;

        always_ff @(posedge clk) begin
            if (wr_data_en_i && (wr_word_i == WW'(gi))) data_mem[wr_index_i] <= wr_data_i;
            if (rd_en_i) rd_q <= data_mem[rd_index_i];
        end

        assign rd_line_o[gi] = rd_q;
    end

endmodule

// File: rtl/icache_nway.sv
// Set-associative instruction cache: FSM, tag compare, round-robin replacement and line refill.
module icache_nway
    import icache_nway_pkg::*;
#(
    parameter int unsigned WAYS       = DEF_WAYS,
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned FETCH      = DEF_FETCH
) (
    input  logic        clk,
    input  logic        reset,
    icache_nway_if.slave bus
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned IW    = idx_w(SETS);
    localparam int unsigned TAG_W = tag_w(LINE_WORDS, SETS);
    localparam int unsigned WW    = clog2_min1(LINE_WORDS);
    localparam int unsigned RW    = clog2_min1(WAYS);

    state_e                    state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [IW-1:0]             inval_idx_q, inval_idx_d;
    logic                      flush_pend_q, flush_pend_d;
    logic [WW-1:0]             beat_q, beat_d;
    logic [RW-1:0]             victim_q, victim_d;
    logic [RW-1:0]             rr_q [SETS];
    logic [LINE_WORDS-1:0][31:0] refill_buf_q;

    logic [TAG_W-1:0]          way_tag   [WAYS];
    logic [LINE_WORDS-1:0][31:0] way_line [WAYS];
    logic [WAYS-1:0]           way_valid;
    logic [WAYS-1:0]           hit_way;
    logic                      any_hit;
    logic [LINE_WORDS-1:0][31:0] hit_line;
    logic [LINE_WORDS-1:0][31:0] out_line;
    logic [FETCH-1:0][31:0]    res_words;

    logic [TAG_W-1:0]          req_tag;
    logic [IW-1:0]             req_idx;
    logic [WW-1:0]             req_wo;
    logic [IW-1:0]             wr_index;
    logic                      addr_ready_int;
    logic                      accept;
    logic                      beat_fire;
    logic                      last_fire;
    logic                      result_valid_int;
    logic                      unused_addr_lsb;

    assign req_tag         = addr_q[31 -: TAG_W];
    assign req_idx         = addr_q[OFF_W +: IW];
    assign req_wo          = addr_q[2 +: WW];
    assign unused_addr_lsb = ^addr_q[1:0];

    assign any_hit   = |hit_way;
    assign beat_fire = (state_q == REFILL) && bus.mem_rvalid;
    assign last_fire = beat_fire && bus.mem_rlast;
    assign wr_index  = (state_q == INVAL) ? inval_idx_q : req_idx;

    // A hit only streams the next request if no flush is waiting to be serviced.
    always_comb begin
        addr_ready_int = 1'b0;
        case (state_q)
            IDLE:    addr_ready_int = !bus.flush;
            LOOKUP:  addr_ready_int = any_hit && !bus.flush && !flush_pend_q;
            default: addr_ready_int = 1'b0;
        endcase
    end

    assign accept = bus.addr_valid && addr_ready_int;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        icache_nway_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk          (clk),
            .reset        (reset),
            .rd_en_i      (accept),
            .rd_index_i   (bus.addr[OFF_W +: IW]),
            .rd_tag_o     (way_tag[gi]),
            .rd_valid_o   (way_valid[gi]),
            .rd_line_o    (way_line[gi]),
            .wr_index_i   (wr_index),
            .wr_word_i    (beat_q),
            .wr_data_i    (bus.mem_rdata),
            .wr_data_en_i (beat_fire && (victim_q == RW'(gi))),
            .wr_tag_en_i  (last_fire && (victim_q == RW'(gi))),
            .wr_tag_i     (req_tag),
            .inv_en_i     ((state_q == INVAL) || ((state_q == MISS_REQ) && (victim_q == RW'(gi))))
        );

        assign hit_way[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
    end

    always_comb begin
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_way[w]) hit_line = hit_line | way_line[w];
        end
    end

    assign out_line = (state_q == RESP) ? refill_buf_q : hit_line;

    for (genvar gi = 0; gi < FETCH; gi++) begin : g_fetch
        assign res_words[gi] = out_line[req_wo + WW'(gi)];
    end

    assign result_valid_int = ((state_q == LOOKUP) && any_hit) || (state_q == RESP);

    assign bus.addr_ready   = addr_ready_int;
    assign bus.result_valid = result_valid_int;
    assign bus.result       = result_valid_int ? res_words : '0;
    assign bus.mem_arvalid  = (state_q == MISS_REQ);
    assign bus.mem_araddr   = (state_q == MISS_REQ) ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.mem_rready   = (state_q == REFILL);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        inval_idx_d  = inval_idx_q;
        flush_pend_d = flush_pend_q;
        beat_d       = beat_q;
        victim_d     = victim_q;
        if (accept) addr_d = bus.addr;
        case (state_q)
            INVAL: begin
                inval_idx_d  = inval_idx_q + 1'b1;
                flush_pend_d = 1'b0;
                if (inval_idx_q == IW'(SETS - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (bus.flush) begin
                    state_d     = INVAL;
                    inval_idx_d = '0;
                end else if (accept) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                flush_pend_d = flush_pend_q | bus.flush;
                if (any_hit) begin
                    if (accept) begin
                        state_d = LOOKUP;
                    end else if (flush_pend_q || bus.flush) begin
                        state_d     = INVAL;
                        inval_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    victim_d = rr_q[req_idx];
                    state_d  = MISS_REQ;
                end
            end
            MISS_REQ: begin
                flush_pend_d = flush_pend_q | bus.flush;
                if (bus.mem_arready) begin
                    state_d = REFILL;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                flush_pend_d = flush_pend_q | bus.flush;
                if (bus.mem_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if (bus.mem_rlast) begin
                        beat_d  = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (flush_pend_q || bus.flush) begin
                    state_d     = INVAL;
                    inval_idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = INVAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= INVAL;
            addr_q       <= '0;
            inval_idx_q  <= '0;
            flush_pend_q <= 1'b0;
            beat_q       <= '0;
            victim_q     <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            inval_idx_q  <= inval_idx_d;
            flush_pend_q <= flush_pend_d;
            beat_q       <= beat_d;
            victim_q     <= victim_d;
            if (last_fire) begin
                rr_q[req_idx] <= (rr_q[req_idx] == RW'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
            end
        end
    end

    // The response is served from this copy so the arrays need no second read.
    always_ff @(posedge clk) begin
        if (beat_fire) refill_buf_q[beat_q] <= bus.mem_rdata;
    end

    a_onehot_hit: assert property (@(posedge clk) disable iff (reset)
        (state_q == LOOKUP) |-> $onehot0(hit_way));
    a_rlast_early: assert property (@(posedge clk) disable iff (reset)
        (beat_fire && bus.mem_rlast) |-> (beat_q == WW'(LINE_WORDS - 1)));
    a_rlast_missing: assert property (@(posedge clk) disable iff (reset)
        (beat_fire && (beat_q == WW'(LINE_WORDS - 1))) |-> bus.mem_rlast);

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway: burst memory model, result monitor and scenario tasks.
module tb_icache_nway;

    localparam int WAYS = 2, SETS = 64, LW = 8, FETCH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    icache_nway_if #(.FETCH(FETCH)) bus();

    icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .FETCH(FETCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [127:0] sb [$];
    int last_res_cyc = 0, prev_res_cyc = 0;

    int ar_stall = 0, stall_cnt = 0, ar_count = 0, rlast_cyc = 0;
    logic [31:0] last_ar = '0, m_base = '0;
    int m_beat = 0;
    bit m_busy = 1'b0;

    function automatic logic [127:0] exp_words(input logic [31:0] a);
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: data word = its own byte address.
    initial begin
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rlast   = 1'b0;
        bus.mem_rdata   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.mem_arready = 1'b0;
                bus.mem_rvalid  = 1'b0;
                bus.mem_rlast   = 1'b0;
                m_busy = 1'b0;
                stall_cnt = 0;
            end else if (!m_busy) begin
                if (bus.mem_arready) begin
                    bus.mem_arready = 1'b0;
                    m_beat = 0;
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = m_base;
                    bus.mem_rlast  = 1'b0;
                    m_busy = 1'b1;
                end else if (bus.mem_arvalid) begin
                    if (stall_cnt < ar_stall) begin
                        stall_cnt++;
                    end else begin
                        bus.mem_arready = 1'b1;
                        m_base  = bus.mem_araddr;
                        last_ar = bus.mem_araddr;
                        ar_count++;
                        stall_cnt = 0;
                    end
                end
            end else begin
                if (bus.mem_rlast) begin
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rlast  = 1'b0;
                    bus.mem_rdata  = '0;
                    m_busy = 1'b0;
                end else begin
                    m_beat++;
                    bus.mem_rdata = m_base + 32'(4 * m_beat);
                    bus.mem_rlast = (m_beat == LW - 1);
                    if (m_beat == LW - 1) rlast_cyc = cyc;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && bus.result_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result got=%h", bus.result);
            end else begin
                logic [127:0] e;
                e = sb.pop_front();
                if (bus.result !== e) begin
                    n_bad++;
                    $display("FAIL result got=%h exp=%h", bus.result, e);
                end else begin
                    $display("result ok %h at cycle %0d", bus.result, cyc);
                end
            end
            prev_res_cyc = last_res_cyc;
            last_res_cyc = cyc;
        end
    end

    task automatic send(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        bus.addr_valid = 1'b1;
        bus.addr = a;
        sb.push_back(exp_words(a));
        while (!bus.addr_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout addr=%h waited=%0d", a, n);
        end
        @(posedge clk);
    endtask

    task automatic idle_wait();
        int n = 0;
        @(negedge clk);
        bus.addr_valid = 1'b0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout pending=%0d", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_req(input logic [31:0] a, output int ar_delta);
        int ar0;
        ar0 = ar_count;
        send(a);
        idle_wait();
        ar_delta = ar_count - ar0;
    endtask

    task automatic count_inval(input string name);
        int n = 0;
        while (!bus.addr_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n !== SETS) begin
            n_bad++;
            $display("FAIL %s inval_cycles got=%0d exp=%0d", name, n, SETS);
        end else $display("%s: addr_ready low %0d cycles", name, n);
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        outs = {bus.addr_ready, bus.result_valid, bus.result, bus.mem_arvalid, bus.mem_araddr, bus.mem_rready};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        reset = 1'b0;
        count_inval("reset_inval");
        n_cmp++;
        if (ar_count !== 0) begin
            n_bad++;
            $display("FAIL reset_no_ar got=%0d exp=0", ar_count);
        end
    endtask

    task automatic test_cold_miss();
        int d;
        do_req(32'h100, d);
        n_cmp++;
        if (d !== 1) begin n_bad++; $display("FAIL cold_miss_ar got=%0d exp=1", d); end
        n_cmp++;
        if (last_ar !== 32'h100) begin n_bad++; $display("FAIL cold_araddr got=%h exp=100", last_ar); end
        n_cmp++;
        if (last_res_cyc !== rlast_cyc + 1) begin
            n_bad++;
            $display("FAIL cold_resp_latency got=%0d exp=%0d", last_res_cyc, rlast_cyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        int ar0;
        ar0 = ar_count;
        send(32'h100);
        send(32'h110);
        idle_wait();
        n_cmp++;
        if (ar_count !== ar0) begin n_bad++; $display("FAIL hit_sweep_ar got=%0d exp=%0d", ar_count, ar0); end
        n_cmp++;
        if (last_res_cyc - prev_res_cyc !== 1) begin
            n_bad++;
            $display("FAIL hit_sweep_spacing got=%0d exp=1", last_res_cyc - prev_res_cyc);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] addrs [5] = '{32'h900, 32'h1100, 32'h900, 32'h1100, 32'h100};
        int exp_d [5] = '{1, 1, 0, 0, 1};
        int d;
        for (int i = 0; i < 5; i++) begin
            do_req(addrs[i], d);
            n_cmp++;
            if (d !== exp_d[i]) begin
                n_bad++;
                $display("FAIL conflict_%0d addr=%h ar got=%0d exp=%0d", i, addrs[i], d, exp_d[i]);
            end else $display("conflict addr=%h refills=%0d", addrs[i], d);
        end
    endtask

    task automatic test_flush_refill();
        int n = 0;
        int d;
        send(32'h2000);
        @(negedge clk);
        bus.addr_valid = 1'b0;
        while (!bus.mem_rvalid && n < 200) begin @(negedge clk); n++; end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n = 0;
        while (!bus.result_valid && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        count_inval("flush_inval");
        n_cmp++;
        if (sb.size() !== 0) begin n_bad++; $display("FAIL flush_result_lost pending=%0d", sb.size()); end
        do_req(32'h2000, d);
        n_cmp++;
        if (d !== 1) begin n_bad++; $display("FAIL flush_remiss got=%0d exp=1", d); end
        do_req(32'h100, d);
        n_cmp++;
        if (d !== 1) begin n_bad++; $display("FAIL flush_old_line got=%0d exp=1", d); end
    endtask

    task automatic test_ar_stall_reset();
        int n = 0;
        int hold = 0;
        int d;
        bit stable = 1'b1;
        logic [255:0] outs;
        ar_stall = 10;
        send(32'h3000);
        @(negedge clk);
        bus.addr_valid = 1'b0;
        @(posedge clk); #1;
        while (!bus.mem_arvalid && n < 200) begin @(posedge clk); #1; n++; end
        while (bus.mem_arvalid && hold < 200) begin
            if (bus.mem_araddr !== 32'h3000) stable = 1'b0;
            hold++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!stable || hold !== ar_stall + 1) begin
            n_bad++;
            $display("FAIL ar_stall stable=%0d hold got=%0d exp=%0d", stable, hold, ar_stall + 1);
        end else $display("ar_stall: arvalid held %0d cycles", hold);
        idle_wait();
        ar_stall = 0;

        send(32'h4000);
        @(negedge clk);
        bus.addr_valid = 1'b0;
        n = 0;
        while (!bus.mem_rvalid && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.mem_rready !== 1'b1) begin n_bad++; $display("FAIL refill_rready got=%b exp=1", bus.mem_rready); end
        #2 reset = 1'b1;
        #1;
        outs = {bus.addr_ready, bus.result_valid, bus.result, bus.mem_arvalid, bus.mem_araddr, bus.mem_rready};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL async_reset_outputs got=%h exp=0", outs); end
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_inval("midrefill_reset_inval");
        do_req(32'h4000, d);
        n_cmp++;
        if (d !== 1) begin n_bad++; $display("FAIL post_reset_miss got=%0d exp=1", d); end
    endtask

    initial begin
        bus.addr = '0;
        bus.addr_valid = 1'b0;
        bus.flush = 1'b0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_refill();
        test_ar_stall_reset();
        n_cmp++;
        if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain pending=%0d", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
